mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. It consumes the EX-MEM register outputs, performs loads and stores over a req/gnt/rvalid data-memory bus, and aligns and extends load data.
- Drives the MEM-WB register and raises a stall to the hazard logic while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath and address width (only 32 supported).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- pcM_i  in  XLEN  instruction PC.
- instrM_i  in  XLEN  instruction word.
- operationM_i  in  operation_e  decoded operation.
- rdM_port_i  in  rd_port_t  destination {addr, data, valid}.
- memM_wrt_ena_i  in  1  store enable from EX.
- memM_addr_i  in  XLEN  effective address (rs1+imm).
- memM_wdata_i  in  XLEN  store data (rs2).
- stallM_i  in  1  incoming bubble marker; no access when high.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1=write.
- dmem_be_o  out  4  byte enables.
- dmem_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata_o  out  XLEN  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  response valid (loads and stores).
- dmem_rdata_i  in  XLEN  read data.
- stall_o  out  1  hold upstream stages (combinational).
- pcW_o, instrW_o  out  XLEN  registered pass-through.
- operationW_o  out  operation_e  registered.
- rdW_port_o  out  rd_port_t  registered write-back port.
- misalignedW_o  out  1  registered misaligned-access flag.

Behaviour:
- Reset (rst_i=1 at clk edge): FSM->IDLE; every W output 0; operationW_o=UNKNOWN.
- Reset also combinationally forces dmem_req_o=0 and stall_o=0.
- After reset, a stale dmem_rvalid_i arriving in IDLE is ignored.
- mem_op: operationM_i in {LB,LH,LW,LBU,LHU}, or in {SB,SH,SW} with memM_wrt_ena_i=1; in both cases stallM_i=0.
- Misalignment: H ops with addr[0]=1, or W ops with addr[1:0]!=0.
- Non-mem op: 1-cycle pass-through, no stall. rdW_port_o = rdM_port_i.
- FSM states IDLE, REQ, WAIT:
  - IDLE with an aligned mem_op: dmem_req_o=1 combinationally in the same cycle. gnt=1 -> WAIT, else -> REQ.
  - REQ: hold req, we, be, addr and wdata stable until gnt; gnt -> WAIT.
  - WAIT: req=0; on rvalid -> IDLE and the access completes.
  - rvalid in IDLE or REQ is ignored. gnt and rvalid in the same cycle are not legal (rvalid is earliest the cycle after gnt).
- stall_o=1 whenever an aligned mem_op is present and this is not its completion cycle (WAIT with rvalid=1). Upstream holds all M inputs stable while stall_o=1.
- While stall_o=1 the MEM-WB register loads a bubble: rd valid=0, operation=UNKNOWN, misaligned=0.
- On completion, MEM-WB captures the instruction. Minimum access latency is 2 cycles (1 stall cycle).
- Load result by addr[1:0]:
  - LB/LBU select byte addr[1:0], sign-/zero-extended.
  - LH/LHU select half addr[1], sign-/zero-extended.
  - LW takes the full word.
  - Result overrides rdM_port_i.data; valid = rdM_port_i.valid.
- Store encoding:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - SW: be=4'hF.
  - Stores write rdW valid=0.
- Misaligned mem_op: no bus request, no stall. Registers misalignedW_o=1 with rd valid=0 for one cycle.
- Store with memM_wrt_ena_i=0, or any op with stallM_i=1: treated as a non-mem bubble; rd valid passes as given.

Decomposition:
- riscv_pkg already holds XLEN, operation_e and rd_port_t.
- Add to riscv_pkg: mem_state_e {IDLE,REQ,WAIT} and dmem_req_t {we, be, addr, wdata}.
- One sub-module: mem_load_align (combinational: rdata, addr[1:0], operation -> extended result). Store lane encoding stays inline.

Test Plan:
- ADD with rd data 0x5, valid=1 -> next cycle rdW_port_o={addr, 0x5, 1}; stall_o never high; dmem_req_o=0.
- LB addr 0x1003, gnt same cycle, rvalid next cycle with rdata=0x80FF_0000 -> stall_o high 1 cycle; rdW data=0xFFFF_FF80. LBU gives 0x0000_0080.
- SH addr 0x2002, wdata 0x1234_ABCD, gnt delayed 3 cycles -> req, be=4'b1100, wdata=0xABCD_ABCD held stable for all 4 cycles; completes on rvalid; rdW valid=0.
- LW addr 0x1001 -> no dmem_req_o, no stall; misalignedW_o=1 and rd valid=0 for one cycle.
- rst_i=1 while in WAIT -> next cycle FSM IDLE, outputs zero, operationW_o=UNKNOWN; a following rvalid is ignored.
- Back-to-back LW 0x0, then SW 0x4 with zero-wait bus -> two accesses serialized, each with 1 stall cycle; MEM-WB order preserved.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: types shared by the pipeline stages.
//   XLEN         - datapath and address width (32 only)
//   operation_e  - decoded operation; UNKNOWN (all zeros) marks a bubble
//   rd_port_t    - destination register port {addr, data, valid}
//   mem_state_e  - data-memory access FSM states
//   dmem_req_t   - data-memory request fields {we, be, addr, wdata}
//   op_is_*      - operation classification helpers
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        UNKNOWN = 5'd0,
        ADD     = 5'd1,
        SUB     = 5'd2,
        XOR     = 5'd3,
        OR      = 5'd4,
        AND     = 5'd5,
        SLL     = 5'd6,
        SRL     = 5'd7,
        SRA     = 5'd8,
        SLT     = 5'd9,
        SLTU    = 5'd10,
        LUI     = 5'd11,
        AUIPC   = 5'd12,
        JAL     = 5'd13,
        JALR    = 5'd14,
        BEQ     = 5'd15,
        BNE     = 5'd16,
        LB      = 5'd17,
        LH      = 5'd18,
        LW      = 5'd19,
        LBU     = 5'd20,
        LHU     = 5'd21,
        SB      = 5'd22,
        SH      = 5'd23,
        SW      = 5'd24
    } operation_e;

    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        logic            valid;
    } rd_port_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic            we;
        logic [3:0]      be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    function automatic logic op_is_load(input operation_e op);
        case (op)
            LB, LH, LW, LBU, LHU: op_is_load = 1'b1;
            default:              op_is_load = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input operation_e op);
        case (op)
            SB, SH, SW: op_is_store = 1'b1;
            default:    op_is_store = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_half(input operation_e op);
        case (op)
            LH, LHU, SH: op_is_half = 1'b1;
            default:     op_is_half = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_word(input operation_e op);
        case (op)
            LW, SW:  op_is_word = 1'b1;
            default: op_is_word = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed byte/half/word from the read data
// and sign- or zero-extends it according to the load operation.
//   rdata     in  raw word returned by the data memory
//   offset    in  byte offset within the word (addr[1:0])
//   operation in  load operation (non-loads pass rdata through)
//   result    out aligned, extended load value
module mem_load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  operation_e      operation,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by extension.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        result = rdata;
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (operation)
            LB:      result = {{24{byte_s[7]}}, byte_s};
            LBU:     result = {24'h000000, byte_s};
            LH:      result = {{16{half_s[15]}}, half_s};
            LHU:     result = {16'h0000, half_s};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between EX-MEM and MEM-WB.
// Issues loads/stores on a req/gnt/rvalid bus, aligns load data, stalls
// upstream while an access is outstanding and drives the MEM-WB register.
//   clk_i, rst_i            clock, synchronous active-high reset
//   pcM_i .. stallM_i       EX-MEM register outputs
//   dmem_*                  data-memory bus (req/we/be/addr/wdata out,
//                           gnt/rvalid/rdata in)
//   stall_o                 combinational hold to the hazard logic
//   pcW_o .. misalignedW_o  MEM-WB register outputs
module mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pcM_i,
    input  logic [XLEN-1:0] instrM_i,
    input  operation_e      operationM_i,
    input  rd_port_t        rdM_port_i,
    input  logic            memM_wrt_ena_i,
    input  logic [XLEN-1:0] memM_addr_i,
    input  logic [XLEN-1:0] memM_wdata_i,
    input  logic            stallM_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            stall_o,
    output logic [XLEN-1:0] pcW_o,
    output logic [XLEN-1:0] instrW_o,
    output operation_e      operationW_o,
    output rd_port_t        rdW_port_o,
    output logic            misalignedW_o
);

    logic            is_load_s;
    logic            is_store_s;
    logic            mem_op_s;
    logic            misaligned_s;
    logic            access_s;
    logic            req_s;
    logic            done_s;
    mem_state_e      state_r;
    mem_state_e      state_next_s;
    dmem_req_t       dreq_s;
    logic [XLEN-1:0] load_data_s;

    // Classify the incoming instruction; a bubble or a disabled store is
    // not a memory operation at all.
    always_comb begin
        is_load_s    = op_is_load(operationM_i);
        is_store_s   = op_is_store(operationM_i);
        mem_op_s     = !stallM_i && (is_load_s || (is_store_s && memM_wrt_ena_i));
        misaligned_s = mem_op_s &&
                       ((op_is_half(operationM_i) && memM_addr_i[0]) ||
                        (op_is_word(operationM_i) && (memM_addr_i[1:0] != 2'b00)));
        access_s     = mem_op_s && !misaligned_s;
    end

    // Request fields: word address, byte lanes and lane-replicated data.
    always_comb begin
        dreq_s.we    = is_store_s;
        dreq_s.addr  = {memM_addr_i[31:2], 2'b00};
        dreq_s.be    = 4'h0;
        dreq_s.wdata = 32'h0000_0000;
        case (operationM_i)
            SB, LB, LBU: begin
                dreq_s.be    = 4'b0001 << memM_addr_i[1:0];
                dreq_s.wdata = {4{memM_wdata_i[7:0]}};
            end
            SH, LH, LHU: begin
                dreq_s.be    = 4'b0011 << memM_addr_i[1:0];
                dreq_s.wdata = {2{memM_wdata_i[15:0]}};
            end
            SW, LW: begin
                dreq_s.be    = 4'hF;
                dreq_s.wdata = memM_wdata_i;
            end
            default: begin
                dreq_s.be    = 4'h0;
                dreq_s.wdata = 32'h0000_0000;
            end
        endcase
    end

    // Access FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Access FSM next state; the request is raised in the same cycle the
    // instruction arrives and held until granted. rvalid only counts in WAIT.
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    req_s        = 1'b1;
                    state_next_s = dmem_gnt_i ? WAIT : REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                req_s = 1'b1;
                if (dmem_gnt_i) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    done_s       = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Reset masks the request and stall combinationally.
    assign dmem_req_o = req_s && !rst_i;
    assign stall_o    = access_s && !done_s && !rst_i;

    // Bus fields are driven only alongside an active request.
    always_comb begin
        if (dmem_req_o) begin
            dmem_we_o    = dreq_s.we;
            dmem_be_o    = dreq_s.be;
            dmem_addr_o  = dreq_s.addr;
            dmem_wdata_o = dreq_s.wdata;
        end else begin
            dmem_we_o    = 1'b0;
            dmem_be_o    = 4'h0;
            dmem_addr_o  = 32'h0000_0000;
            dmem_wdata_o = 32'h0000_0000;
        end
    end

    mem_load_align u_load_align (
        .rdata     (dmem_rdata_i),
        .offset    (memM_addr_i[1:0]),
        .operation (operationM_i),
        .result    (load_data_s)
    );

    // MEM-WB register: bubble while stalled, otherwise capture the
    // instruction with load data merged and write-back suppressed for
    // stores and misaligned accesses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcW_o         <= 32'h0000_0000;
            instrW_o      <= 32'h0000_0000;
            operationW_o  <= UNKNOWN;
            rdW_port_o    <= '0;
            misalignedW_o <= 1'b0;
        end else if (stall_o) begin
            pcW_o         <= 32'h0000_0000;
            instrW_o      <= 32'h0000_0000;
            operationW_o  <= UNKNOWN;
            rdW_port_o    <= '0;
            misalignedW_o <= 1'b0;
        end else begin
            pcW_o            <= pcM_i;
            instrW_o         <= instrM_i;
            operationW_o     <= operationM_i;
            rdW_port_o.addr  <= rdM_port_i.addr;
            rdW_port_o.data  <= (access_s && is_load_s) ? load_data_s : rdM_port_i.data;
            rdW_port_o.valid <= rdM_port_i.valid && !misaligned_s && !(access_s && is_store_s);
            misalignedW_o    <= misaligned_s;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed stimulus for mem_stage, checked
// against a transaction-level model of the stage. The bench plays the
// data-memory bus with a chosen grant delay and response latency per access.
module tb_mem_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] pcM_i, instrM_i, memM_addr_i, memM_wdata_i;
    operation_e  operationM_i;
    rd_port_t    rdM_port_i;
    logic        memM_wrt_ena_i, stallM_i;
    logic        dmem_req_o, dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic [31:0] pcW_o, instrW_o;
    operation_e  operationW_o;
    rd_port_t    rdW_port_o;
    logic        misalignedW_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk_i(clk), .rst_i(rst_i),
        .pcM_i(pcM_i), .instrM_i(instrM_i), .operationM_i(operationM_i),
        .rdM_port_i(rdM_port_i), .memM_wrt_ena_i(memM_wrt_ena_i),
        .memM_addr_i(memM_addr_i), .memM_wdata_i(memM_wdata_i), .stallM_i(stallM_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .pcW_o(pcW_o), .instrW_o(instrW_o),
        .operationW_o(operationW_o), .rdW_port_o(rdW_port_o), .misalignedW_o(misalignedW_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input operation_e op);
        if (op inside {LB, LBU, SB}) return 1;
        if (op inside {LH, LHU, SH}) return 2;
        if (op inside {LW, SW})      return 4;
        return 0;
    endfunction

    function automatic logic [31:0] m_load(input operation_e op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        logic [31:0] v;
        int          sz;
        sz = m_size(op);
        if (sz == 1) begin
            v = (rdata >> (8 * (addr % 4))) & 32'hFF;
            if (op == LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = (rdata >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
            if (op == LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_be(input operation_e op, input logic [31:0] addr);
        int sz;
        sz = m_size(op);
        return ((32'd1 << sz) - 32'd1) << (addr % 4);
    endfunction

    function automatic logic [31:0] m_wdata(input operation_e op, input logic [31:0] w);
        int sz;
        sz = m_size(op);
        if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    // Present one instruction and play the bus: grant after gd cycles,
    // response rl cycles after the grant. noise: 0 none, 1 random, 2 always
    // raise rvalid before the grant (must be ignored).
    task automatic run_instr(input operation_e op, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [4:0] rda, input logic [31:0] rdd, input logic rdv,
                             input logic wen, input logic stm, input int gd, input int rl,
                             input logic [31:0] rdata, input int noise);
        bit          is_ld, is_st, mem, mis, acc;
        int          sz, last;
        logic [31:0] pc, instr;
        pc    = $urandom();
        instr = $urandom();
        pcM_i = pc; instrM_i = instr; operationM_i = op;
        rdM_port_i.addr = rda; rdM_port_i.data = rdd; rdM_port_i.valid = rdv;
        memM_wrt_ena_i = wen; memM_addr_i = addr; memM_wdata_i = wd; stallM_i = stm;
        is_ld = (op inside {LB, LH, LW, LBU, LHU});
        is_st = (op inside {SB, SH, SW});
        sz    = m_size(op);
        mem   = !stm && (is_ld || (is_st && wen));
        mis   = mem && ((sz == 2 && (addr % 2) != 0) || (sz == 4 && (addr % 4) != 0));
        acc   = mem && !mis;
        last  = acc ? gd + 1 + rl : 0;
        for (int k = 0; k <= last; k++) begin
            dmem_gnt_i    = acc && (k == gd);
            dmem_rvalid_i = 1'b0;
            if (acc && k == last) dmem_rvalid_i = 1'b1;
            else if (k < gd || !acc) begin
                if (noise == 2) dmem_rvalid_i = 1'b1;
                else if (noise == 1) dmem_rvalid_i = 1'($urandom_range(0, 1));
            end
            dmem_rdata_i = (k == last) ? rdata : $urandom();
            @(negedge clk);
            check_eq("req", 32'(dmem_req_o), 32'(acc && k <= gd));
            check_eq("stall", 32'(stall_o), 32'(acc && k < last));
            if (acc && k <= gd) begin
                check_eq("we", 32'(dmem_we_o), 32'(is_st));
                check_eq("addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
                if (is_st) begin
                    check_eq("be", 32'(dmem_be_o), m_be(op, addr));
                    check_eq("wdata", dmem_wdata_o, m_wdata(op, wd));
                end
            end
            @(posedge clk);
            #1;
            if (k < last) begin
                check_eq("bub_valid", 32'(rdW_port_o.valid), 32'd0);
                check_eq("bub_op", 32'(operationW_o), 32'(UNKNOWN));
                check_eq("bub_mis", 32'(misalignedW_o), 32'd0);
            end else begin
                check_eq("pcW", pcW_o, pc);
                check_eq("instrW", instrW_o, instr);
                check_eq("opW", 32'(operationW_o), 32'(op));
                check_eq("rdW_addr", 32'(rdW_port_o.addr), 32'(rda));
                check_eq("rdW_data", rdW_port_o.data, (acc && is_ld) ? m_load(op, addr, rdata) : rdd);
                check_eq("rdW_valid", 32'(rdW_port_o.valid), 32'(rdv && !mis && !(acc && is_st)));
                check_eq("misW", 32'(misalignedW_o), 32'(mis));
            end
        end
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    task automatic check_w_zero(input string tag);
        check_eq({tag, "_pc"}, pcW_o, 32'd0);
        check_eq({tag, "_instr"}, instrW_o, 32'd0);
        check_eq({tag, "_op"}, 32'(operationW_o), 32'(UNKNOWN));
        check_eq({tag, "_rd_addr"}, 32'(rdW_port_o.addr), 32'd0);
        check_eq({tag, "_rd_data"}, rdW_port_o.data, 32'd0);
        check_eq({tag, "_rd_valid"}, 32'(rdW_port_o.valid), 32'd0);
        check_eq({tag, "_mis"}, 32'(misalignedW_o), 32'd0);
    endtask

    operation_e op_list [14] = '{ADD, SUB, XOR, LUI, JAL, BEQ, LB, LH, LW, LBU, LHU, SB, SH, SW};

    initial begin
        // Reset with an aligned load presented: bus and stall stay low.
        rst_i = 1'b1;
        pcM_i = 32'h10; instrM_i = 32'h1234; operationM_i = LW;
        rdM_port_i.addr = 5'd3; rdM_port_i.data = 32'h77; rdM_port_i.valid = 1'b1;
        memM_wrt_ena_i = 1'b0; memM_addr_i = 32'h100; memM_wdata_i = 32'h0; stallM_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", 32'(dmem_req_o), 32'd0);
        check_eq("rst_stall", 32'(stall_o), 32'd0);
        check_w_zero("rst");
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Directed cases.
        run_instr(ADD, 32'h0, 32'h0, 5'd7, 32'h5, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0, 0);
        run_instr(LB, 32'h1003, 32'h0, 5'd8, 32'hDEAD, 1'b1, 1'b0, 1'b0, 0, 0, 32'h80FF_0000, 0);
        run_instr(LBU, 32'h1003, 32'h0, 5'd9, 32'hDEAD, 1'b1, 1'b0, 1'b0, 0, 0, 32'h80FF_0000, 0);
        run_instr(SH, 32'h2002, 32'h1234_ABCD, 5'd10, 32'h1, 1'b1, 1'b1, 1'b0, 3, 1, 32'h0, 0);
        run_instr(LW, 32'h1001, 32'h0, 5'd11, 32'h2, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0, 0);
        run_instr(LW, 32'h0, 32'h0, 5'd12, 32'h3, 1'b1, 1'b0, 1'b0, 0, 0, 32'hCAFE_F00D, 0);
        run_instr(SW, 32'h4, 32'h5555_AAAA, 5'd13, 32'h4, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0, 0);
        run_instr(SB, 32'h31, 32'h0000_00A5, 5'd1, 32'h4, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0, 0);
        run_instr(LH, 32'h42, 32'h0, 5'd2, 32'h0, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0, 0);

        // Reset while waiting for the response, then a stale rvalid in IDLE.
        pcM_i = 32'h40; instrM_i = 32'h99; operationM_i = LW;
        rdM_port_i.addr = 5'd4; rdM_port_i.data = 32'h0; rdM_port_i.valid = 1'b1;
        memM_wrt_ena_i = 1'b0; memM_addr_i = 32'h200; stallM_i = 1'b0;
        dmem_gnt_i = 1'b1;
        @(negedge clk);
        check_eq("wr_req", 32'(dmem_req_o), 32'd1);
        @(posedge clk);
        #1;
        dmem_gnt_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        check_eq("wr_rst_req", 32'(dmem_req_o), 32'd0);
        check_eq("wr_rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        check_w_zero("wr_rst");
        rst_i = 1'b0;
        run_instr(LW, 32'h200, 32'h0, 5'd4, 32'h0, 1'b1, 1'b0, 1'b0, 2, 0, 32'h0BAD_BEEF, 2);

        // Randomized instruction stream.
        for (int n = 0; n < 400; n++) begin
            operation_e  op;
            logic [31:0] addr;
            int          sz;
            op   = op_list[$urandom_range(0, 13)];
            addr = $urandom();
            sz   = m_size(op);
            if (sz > 1 && $urandom_range(0, 9) < 7) addr = addr & ~(32'(sz) - 32'd1);
            run_instr(op, addr, $urandom(), 5'($urandom_range(0, 31)), $urandom(),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
                      1'($urandom_range(0, 9) == 0), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom(), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
